// File: rtl/decoder_pkg.sv
// Shared types and helpers for the parametrised one-hot decoder / address scanner.
package decoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // One bit of a binary-to-one-hot decode: true when output index idx is selected by addr.
  function automatic logic onehot_bit(input int addr, input int idx);
    return (addr == idx);
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Purely combinational binary-to-one-hot decoder, active-high output.
module onehot_decoder
  import decoder_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [2**ADDR_W-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      onehot[i] = onehot_bit(int'(addr), i);
    end
  end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with single-shot and wrap-around scan modes behind a
// valid/ready request port; all outputs come straight from flops.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HOLD       = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_mode,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [ADDR_W-1:0]     i_len,
  input  logic                  i_abort,
  output logic [2**ADDR_W-1:0]  o_selector,
  output logic                  o_sel_valid,
  output logic [ADDR_W-1:0]     o_addr,
  output logic                  o_done
);

  localparam int SEL_W = 2**ADDR_W;
  localparam logic [SEL_W-1:0] SEL_INACTIVE = {SEL_W{ACTIVE_LOW}};

  // Handshake: a request transfers on the rising edge where i_valid and o_ready are
  // both high; o_ready is high exactly while the FSM is in ST_IDLE, and the requester
  // must hold i_valid and its payload until that edge.
  logic accept;
  assign accept = i_valid & o_ready;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] cur_q, cur_n;
  logic [ADDR_W-1:0] rem_q, rem_n;
  logic              live_n;
  logic              done_n;
  logic [SEL_W-1:0]  dec;
  logic [SEL_W-1:0]  sel_n;
  logic [ADDR_W-1:0] addr_n;

  // cur_q always holds the address being shown this cycle; cur_n is next cycle's.
  always_comb begin
    state_n = state_q;
    cur_n   = cur_q;
    rem_n   = rem_q;
    live_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cur_n  = i_addr;
          live_n = 1'b1;
          if (i_mode == MODE_SINGLE) begin
            done_n = 1'b1;
          end else begin
            state_n = ST_SCAN;
            rem_n   = i_len;
            done_n  = (i_len == '0);
          end
        end
      end
      ST_SCAN: begin
        // The final selection ends the request regardless of abort.
        if (rem_q == '0) begin
          state_n = ST_IDLE;
        end else if (i_abort) begin
          state_n = ST_IDLE;
        end else begin
          cur_n  = cur_q + 1'b1;
          rem_n  = rem_q - 1'b1;
          live_n = 1'b1;
          done_n = (rem_q == ADDR_W'(1));
        end
      end
    endcase
  end

  onehot_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .addr   (cur_n),
    .onehot (dec)
  );

  always_comb begin
    if (live_n) begin
      sel_n  = ACTIVE_LOW ? ~dec : dec;
      addr_n = cur_n;
    end else if (HOLD) begin
      sel_n  = o_selector;
      addr_n = o_addr;
    end else begin
      sel_n  = SEL_INACTIVE;
      addr_n = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      o_ready     <= 1'b1;
      o_sel_valid <= 1'b0;
      o_done      <= 1'b0;
      o_addr      <= '0;
      o_selector  <= SEL_INACTIVE;
    end else begin
      state_q     <= state_n;
      cur_q       <= cur_n;
      rem_q       <= rem_n;
      o_ready     <= (state_n == ST_IDLE);
      o_sel_valid <= live_n;
      o_done      <= done_n;
      o_addr      <= addr_n;
      o_selector  <= sel_n;
    end
  end

endmodule
